// File: rtl/ram_arbiter_pkg.sv
// Shared constants for the single-port RAM arbiter: FSM encoding and fetch bus defaults.
package ram_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_D_WAIT = 2'd1;
  localparam logic [1:0] ARB_I_WAIT = 2'd2;
  localparam logic [1:0] ARB_TURN   = 2'd3;

  localparam logic [3:0] SEL_WORD = 4'hF;

  function automatic logic arb_is_wait(input logic [1:0] st);
    return (st == ARB_D_WAIT) || (st == ARB_I_WAIT);
  endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Shares one single-ported RAM bus between instruction fetch and the data port.
// Data has priority; each transaction ends on ack or timeout and is followed by one TURN cycle.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              inst_ce_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic [DATA_W-1:0] inst_data_o,
  output logic              inst_ready_o,
  output logic              inst_err_o,
  input  logic              data_ce_i,
  input  logic              data_we_i,
  input  logic [3:0]        data_sel_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_data_i,
  output logic [DATA_W-1:0] data_data_o,
  output logic              data_ready_o,
  output logic              data_err_o,
  output logic              bus_ce_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_data_o,
  input  logic [DATA_W-1:0] bus_data_i,
  input  logic              bus_ack_i
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_discard;
  logic [DATA_W-1:0] r_inst_data;
  logic              r_inst_ready;
  logic              r_inst_err;
  logic [DATA_W-1:0] r_data_data;
  logic              r_data_ready;
  logic              r_data_err;
  logic              r_bus_ce;
  logic              r_bus_we;
  logic [3:0]        r_bus_sel;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_data;

  logic              w_wait;
  logic              w_ack;
  logic              w_timeout;
  logic              w_inst_drop;
  logic [DATA_W-1:0] w_result;

  assign w_wait      = arb_is_wait(r_state);
  assign w_ack       = w_wait && bus_ack_i;
  // An ack in the last allowed wait cycle still wins over the timeout.
  assign w_timeout   = w_wait && !bus_ack_i && (r_cnt == CNT_LAST);
  assign w_inst_drop = r_discard || flush;
  assign w_result    = w_ack ? bus_data_i : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ARB_IDLE;
      r_cnt        <= '0;
      r_discard    <= 1'b0;
      r_inst_data  <= '0;
      r_inst_ready <= 1'b0;
      r_inst_err   <= 1'b0;
      r_data_data  <= '0;
      r_data_ready <= 1'b0;
      r_data_err   <= 1'b0;
      r_bus_ce     <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_sel    <= '0;
      r_bus_addr   <= '0;
      r_bus_data   <= '0;
    end else begin
      r_inst_ready <= 1'b0;
      r_inst_err   <= 1'b0;
      r_data_ready <= 1'b0;
      r_data_err   <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          r_cnt <= '0;
          if (data_ce_i) begin
            r_bus_ce   <= 1'b1;
            r_bus_we   <= data_we_i;
            r_bus_sel  <= data_sel_i;
            r_bus_addr <= data_addr_i;
            r_bus_data <= data_data_i;
            r_state    <= ARB_D_WAIT;
          end else if (inst_ce_i) begin
            r_bus_ce   <= 1'b1;
            r_bus_we   <= 1'b0;
            r_bus_sel  <= SEL_WORD;
            r_bus_addr <= inst_addr_i;
            r_bus_data <= '0;
            r_discard  <= flush;
            r_state    <= ARB_I_WAIT;
          end
        end
        ARB_D_WAIT, ARB_I_WAIT: begin
          if (w_ack || w_timeout) begin
            r_bus_ce <= 1'b0;
            r_state  <= ARB_TURN;
            if (r_state == ARB_D_WAIT) begin
              r_data_ready <= 1'b1;
              r_data_err   <= w_timeout;
              r_data_data  <= w_result;
            end else if (!w_inst_drop) begin
              r_inst_ready <= 1'b1;
              r_inst_err   <= w_timeout;
              r_inst_data  <= w_result;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
            // A flush while fetching only marks the result stale; the bus cycle still runs out.
            if ((r_state == ARB_I_WAIT) && flush) begin
              r_discard <= 1'b1;
            end
          end
        end
        default: begin
          r_cnt     <= '0;
          r_discard <= 1'b0;
          r_state   <= ARB_IDLE;
        end
      endcase
    end
  end

  assign inst_data_o  = r_inst_data;
  assign inst_ready_o = r_inst_ready;
  assign inst_err_o   = r_inst_err;
  assign data_data_o  = r_data_data;
  assign data_ready_o = r_data_ready;
  assign data_err_o   = r_data_err;
  assign bus_ce_o     = r_bus_ce;
  assign bus_we_o     = r_bus_we;
  assign bus_sel_o    = r_bus_sel;
  assign bus_addr_o   = r_bus_addr;
  assign bus_data_o   = r_bus_data;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized bench for ram_arbiter: a transaction-level model predicts grants, completions and bus contents.
module tb_ram_arbiter;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        inst_ce_i = 1'b0;
  logic [31:0] inst_addr_i = '0;
  logic [31:0] inst_data_o;
  logic        inst_ready_o;
  logic        inst_err_o;
  logic        data_ce_i = 1'b0;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_sel_i = '0;
  logic [31:0] data_addr_i = '0;
  logic [31:0] data_data_i = '0;
  logic [31:0] data_data_o;
  logic        data_ready_o;
  logic        data_err_o;
  logic        bus_ce_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_data_o;
  logic [31:0] bus_data_i = '0;
  logic        bus_ack_i = 1'b0;

  ram_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(T), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .inst_ce_i(inst_ce_i), .inst_addr_i(inst_addr_i), .inst_data_o(inst_data_o),
    .inst_ready_o(inst_ready_o), .inst_err_o(inst_err_o),
    .data_ce_i(data_ce_i), .data_we_i(data_we_i), .data_sel_i(data_sel_i),
    .data_addr_i(data_addr_i), .data_data_i(data_data_i), .data_data_o(data_data_o),
    .data_ready_o(data_ready_o), .data_err_o(data_err_o),
    .bus_ce_o(bus_ce_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o),
    .bus_data_i(bus_data_i), .bus_ack_i(bus_ack_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int k = 0;
  int txn = 0;

  // Transaction-level model: one outstanding bus transaction with known grant and end edges.
  bit          m_busy = 0;
  bit          m_owner_d = 0;
  bit          m_acked = 0;
  bit          m_disc = 0;
  int          m_g = 0;
  int          m_e = 0;
  int          m_free = 0;
  int          m_stray = -10;
  logic        m_we = 0;
  logic [3:0]  m_sel = '0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_word = '0;

  bit          e_ir, e_ie, e_dr, e_de;
  logic [31:0] e_data;

  bit d_pend = 0;
  bit i_pend = 0;
  bit d_done = 0;
  bit i_done = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, k);
    end
  endtask

  task automatic model_edge();
    e_ir = 0; e_ie = 0; e_dr = 0; e_de = 0; e_data = '0;
    d_done = 0; i_done = 0;
    if (m_busy) begin
      if (!m_owner_d && flush) m_disc = 1;
      if (k == m_e) begin
        m_busy = 0;
        m_free = k + 2;
        if (!m_acked) m_stray = k;
        e_data = m_acked ? m_word : 32'h0;
        if (m_owner_d) begin
          e_dr = 1; e_de = !m_acked; d_done = 1; d_pend = 0;
        end else if (!m_disc) begin
          e_ir = 1; e_ie = !m_acked; i_done = 1; i_pend = 0;
        end
        txn++;
        $display("txn %0d %s addr=%h we=%0d sel=%h ack=%0d discard=%0d rdata=%h",
                 txn, m_owner_d ? "data" : "inst", m_addr, m_we, m_sel, m_acked,
                 m_disc && !m_owner_d, e_data);
      end
    end else if (k >= m_free && (data_ce_i || inst_ce_i)) begin
      int n;
      m_busy    = 1;
      m_g       = k;
      m_owner_d = data_ce_i;
      m_disc    = !data_ce_i && flush;
      m_we      = data_ce_i ? data_we_i : 1'b0;
      m_sel     = data_ce_i ? data_sel_i : 4'hF;
      m_addr    = data_ce_i ? data_addr_i : inst_addr_i;
      m_wdata   = data_ce_i ? data_data_i : 32'h0;
      m_word    = $urandom;
      n         = $urandom_range(1, T + 2);
      m_acked   = (n <= T);
      m_e       = k + (m_acked ? n : T);
    end
  endtask

  task automatic check_outputs();
    chk("bus_ce", 32'(bus_ce_o), 32'(m_busy));
    chk("inst_ready", 32'(inst_ready_o), 32'(e_ir));
    chk("inst_err", 32'(inst_err_o), 32'(e_ie));
    chk("data_ready", 32'(data_ready_o), 32'(e_dr));
    chk("data_err", 32'(data_err_o), 32'(e_de));
    if (m_busy) begin
      chk("bus_addr", bus_addr_o, m_addr);
      chk("bus_we", 32'(bus_we_o), 32'(m_we));
      chk("bus_sel", 32'(bus_sel_o), 32'(m_sel));
      chk("bus_wdata", bus_data_o, m_wdata);
    end
    if (e_dr) chk("data_rdata", data_data_o, e_data);
    if (e_ir) chk("inst_rdata", inst_data_o, e_data);
  endtask

  task automatic drive_next();
    flush = ($urandom_range(0, 14) == 0);
    if (flush) begin
      i_pend = 1; inst_ce_i = 1; inst_addr_i = {$urandom_range(0, 4095), 2'b00};
    end else if (i_done && $urandom_range(0, 1) == 1) begin
      // stale ce held through the TURN cycle
    end else if (!i_pend) begin
      if ($urandom_range(0, 1) == 1) begin
        i_pend = 1; inst_ce_i = 1; inst_addr_i = {$urandom_range(0, 4095), 2'b00};
      end else begin
        inst_ce_i = 0;
      end
    end
    if (d_done && $urandom_range(0, 1) == 1) begin
      // stale ce held through the TURN cycle
    end else if (!d_pend) begin
      if ($urandom_range(0, 9) < 4) begin
        d_pend = 1; data_ce_i = 1; data_we_i = $urandom_range(0, 1) == 1;
        data_sel_i = 4'($urandom_range(1, 15)); data_addr_i = $urandom; data_data_i = $urandom;
      end else begin
        data_ce_i = 0;
      end
    end
    bus_data_i = $urandom;
    if (m_busy) begin
      bus_ack_i = m_acked && (k + 1 == m_e);
      if (bus_ack_i) bus_data_i = m_word;
    end else if (k == m_stray) begin
      bus_ack_i = 1;
    end else begin
      bus_ack_i = ($urandom_range(0, 4) == 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    k++;
    model_edge();
    #1;
    check_outputs();
    drive_next();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_bus_ce"}, 32'(bus_ce_o), 32'd0);
    chk({tag, "_bus_addr"}, bus_addr_o, 32'd0);
    chk({tag, "_bus_ctl"}, {27'd0, bus_we_o, bus_sel_o}, 32'd0);
    chk({tag, "_bus_wdata"}, bus_data_o, 32'd0);
    chk({tag, "_flags"}, {28'd0, inst_ready_o, inst_err_o, data_ready_o, data_err_o}, 32'd0);
    chk({tag, "_inst_data"}, inst_data_o, 32'd0);
    chk({tag, "_data_data"}, data_data_o, 32'd0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 0;
    m_busy = 0; d_pend = 0; i_pend = 0; m_stray = -10;
    m_free = k + 1;
  endtask

  initial begin
    int guard;
    #1;
    check_all_zero("reset");
    release_reset();
    for (int i = 0; i < 3000; i++) step();

    // Reset in the middle of a bus transaction.
    guard = 0;
    while (!(m_busy && k > m_g) && guard < 200) begin
      step();
      guard++;
    end
    chk("reach_busy_for_reset", 32'(m_busy), 32'd1);
    #2;
    rst = 1;
    #1;
    check_all_zero("async_rst");
    flush = 0; inst_ce_i = 0; data_ce_i = 0; bus_ack_i = 0;
    release_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      k++;
      #1;
      chk("post_rst_bus_ce", 32'(bus_ce_o), 32'd0);
      chk("post_rst_ready", {30'd0, inst_ready_o, data_ready_o}, 32'd0);
    end
    m_free = k + 1;
    for (int i = 0; i < 400; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
